// File: rtl/data_mem_ctrl.sv
// Data-memory controller between the pipeline MEM stage and a single-port 32-bit RAM.
// Optional address range checking is enabled by defining DMC_RANGE_CHECK_EN.
module data_mem_ctrl #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReadWrite,
  input  logic [1:0]  DataSize,
  input  logic        SignedLoad,
  input  logic [31:0] Address,
  input  logic [63:0] StoreData,
  output logic        RspValid,
  output logic [63:0] LoadData,
  output logic        Error,
  output logic        MemEnable,
  output logic        MemReadWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemDataIn,
  output logic [1:0]  MemDataSize,
  input  logic [31:0] MemDataOut
);

`ifdef DMC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t      state;
  logic        req_rw;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr_next;
  logic [31:0] store_hi;
  logic [31:0] result_lo;

  logic        accept;
  logic [31:0] next_addr;
  logic        range_err;

  always_comb begin
    accept    = ReqValid && ReqReady;
    next_addr = Address + 32'd1;
    range_err = RANGE_EN && ((Address >= DEPTH) ||
                             ((DataSize == 2'b11) && (next_addr >= DEPTH)));
  end

  function automatic logic [63:0] extend(input logic [31:0] d, input logic [1:0] size,
                                         input logic sgn);
    logic [63:0] r;
    case (size)
      2'b00:   r = sgn ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
      2'b01:   r = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
      default: r = sgn ? {{32{d[31]}}, d}       : {32'd0, d};
    endcase
    return r;
  endfunction

  // All outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      ReqReady      <= 1'b1;
      RspValid      <= 1'b0;
      LoadData      <= '0;
      Error         <= 1'b0;
      MemEnable     <= 1'b0;
      MemReadWrite  <= 1'b0;
      MemAddress    <= '0;
      MemDataIn     <= '0;
      MemDataSize   <= '0;
      req_rw        <= 1'b0;
      req_size      <= '0;
      req_signed    <= 1'b0;
      req_addr_next <= '0;
      store_hi      <= '0;
      result_lo     <= '0;
    end else begin
      RspValid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          state    <= IDLE;
          ReqReady <= 1'b1;
          if (accept) begin
            req_rw        <= ReadWrite;
            req_size      <= DataSize;
            req_signed    <= SignedLoad;
            req_addr_next <= next_addr;
            store_hi      <= StoreData[63:32];
            if (range_err) begin
              state    <= RESP;
              RspValid <= 1'b1;
              Error    <= 1'b1;
              LoadData <= '0;
            end else begin
              state        <= BEAT0;
              ReqReady     <= 1'b0;
              MemEnable    <= 1'b1;
              MemReadWrite <= ReadWrite;
              MemAddress   <= Address;
              MemDataIn    <= StoreData[31:0];
              MemDataSize  <= DataSize;
            end
          end
        end
        BEAT0: begin
          if (req_size == 2'b11) begin
            state       <= BEAT1;
            result_lo   <= MemDataOut;
            MemAddress  <= req_addr_next;
            MemDataIn   <= store_hi;
            MemDataSize <= 2'b10;
          end else begin
            state        <= RESP;
            ReqReady     <= 1'b1;
            RspValid     <= 1'b1;
            Error        <= 1'b0;
            LoadData     <= req_rw ? '0 : extend(MemDataOut, req_size, req_signed);
            MemEnable    <= 1'b0;
            MemReadWrite <= 1'b0;
          end
        end
        BEAT1: begin
          state        <= RESP;
          ReqReady     <= 1'b1;
          RspValid     <= 1'b1;
          Error        <= 1'b0;
          LoadData     <= req_rw ? '0 : {MemDataOut, result_lo};
          MemEnable    <= 1'b0;
          MemReadWrite <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with a behavioural 256-word RAM.
// The range-check vectors follow the DMC_RANGE_CHECK_EN build setting.
module tb_data_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReadWrite = 1'b0;
  logic [1:0]  DataSize = 2'b00;
  logic        SignedLoad = 1'b0;
  logic [31:0] Address = '0;
  logic [63:0] StoreData = '0;
  logic        RspValid;
  logic [63:0] LoadData;
  logic        Error;
  logic        MemEnable;
  logic        MemReadWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemDataIn;
  logic [1:0]  MemDataSize;
  logic [31:0] MemDataOut;

  logic [31:0] ram [0:255];

  int vectors = 0;
  int miscompares = 0;

  data_mem_ctrl #(.DEPTH(256)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReadWrite(ReadWrite), .DataSize(DataSize), .SignedLoad(SignedLoad),
    .Address(Address), .StoreData(StoreData), .RspValid(RspValid),
    .LoadData(LoadData), .Error(Error), .MemEnable(MemEnable),
    .MemReadWrite(MemReadWrite), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
    .MemDataSize(MemDataSize), .MemDataOut(MemDataOut)
  );

  always #5 Clk = ~Clk;

  // RAM preload happens under reset so the array has a single writer.
  always @(posedge Clk) begin
    if (Reset) begin
      ram[0]   <= 32'h1234_8001;
      ram[5]   <= 32'h0000_00F3;
      ram[31]  <= 32'h0000_0000;
      ram[255] <= 32'h55AA_55AA;
    end else if (MemEnable && MemReadWrite) begin
      ram[MemAddress[7:0]] <= MemDataIn;
    end
  end
  assign MemDataOut = ram[MemAddress[7:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_req(input logic rw, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [63:0] sdata,
                        output int lat, output logic [63:0] data, output logic err,
                        output logic saw_en);
    ReqValid = 1'b1; ReadWrite = rw; DataSize = size; SignedLoad = sgn;
    Address = addr; StoreData = sdata;
    tick;
    ReqValid = 1'b0;
    lat = 0; data = '0; err = 1'b0; saw_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      saw_en = saw_en | MemEnable;
      if (RspValid) begin
        lat = i; data = LoadData; err = Error;
        break;
      end
      tick;
    end
  endtask

  int          lat;
  logic [63:0] data;
  logic        err;
  logic        saw_en;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick; tick;
    check("rst_rspvalid", 64'(RspValid), 64'd0);
    check("rst_loaddata", LoadData, 64'd0);
    check("rst_error", 64'(Error), 64'd0);
    check("rst_memen", 64'(MemEnable), 64'd0);
    check("rst_memrw", 64'(MemReadWrite), 64'd0);
    check("rst_memaddr", 64'(MemAddress), 64'd0);
    check("rst_memdin", 64'(MemDataIn), 64'd0);
    check("rst_memsize", 64'(MemDataSize), 64'd0);
    check("rst_ready", 64'(ReqReady), 64'd1);

    // request presented while in reset must not be taken
    ReqValid = 1'b1; DataSize = 2'b10; Address = 32'd5;
    tick;
    check("rstprio_memen", 64'(MemEnable), 64'd0);
    check("rstprio_ready", 64'(ReqReady), 64'd1);
    Reset = 1'b0; ReqValid = 1'b0;
    tick;
    check("rstprio_idle", 64'(MemEnable), 64'd0);

    do_req(1'b0, 2'b00, 1'b1, 32'd5, '0, lat, data, err, saw_en);
    check("sbyte_lat", 64'(lat), 64'd2);
    check("sbyte_data", data, 64'hFFFF_FFFF_FFFF_FFF3);
    check("sbyte_err", 64'(err), 64'd0);

    do_req(1'b0, 2'b00, 1'b0, 32'd5, '0, lat, data, err, saw_en);
    check("ubyte_data", data, 64'h0000_0000_0000_00F3);

    do_req(1'b0, 2'b01, 1'b0, 32'd0, '0, lat, data, err, saw_en);
    check("uhalf_lat", 64'(lat), 64'd2);
    check("uhalf_data", data, 64'h0000_0000_0000_8001);

    do_req(1'b0, 2'b01, 1'b1, 32'd0, '0, lat, data, err, saw_en);
    check("shalf_data", data, 64'hFFFF_FFFF_FFFF_8001);

    do_req(1'b1, 2'b10, 1'b0, 32'd20, 64'h0_8000_0000, lat, data, err, saw_en);
    check("wstore_lat", 64'(lat), 64'd2);
    check("wstore_data", data, 64'd0);

    do_req(1'b0, 2'b10, 1'b1, 32'd20, '0, lat, data, err, saw_en);
    check("sword_data", data, 64'hFFFF_FFFF_8000_0000);
    do_req(1'b0, 2'b10, 1'b0, 32'd20, '0, lat, data, err, saw_en);
    check("uword_data", data, 64'h0000_0000_8000_0000);

    // doubleword store, beat-by-beat
    ReqValid = 1'b1; ReadWrite = 1'b1; DataSize = 2'b11; SignedLoad = 1'b0;
    Address = 32'd10; StoreData = 64'h1122_3344_AABB_CCDD;
    tick;
    ReqValid = 1'b0;
    check("dst_b0_en", 64'(MemEnable), 64'd1);
    check("dst_b0_rw", 64'(MemReadWrite), 64'd1);
    check("dst_b0_addr", 64'(MemAddress), 64'd10);
    check("dst_b0_din", 64'(MemDataIn), 64'hAABB_CCDD);
    check("dst_b0_size", 64'(MemDataSize), 64'd3);
    check("dst_b0_ready", 64'(ReqReady), 64'd0);
    tick;
    check("dst_b1_en", 64'(MemEnable), 64'd1);
    check("dst_b1_addr", 64'(MemAddress), 64'd11);
    check("dst_b1_din", 64'(MemDataIn), 64'h1122_3344);
    check("dst_b1_size", 64'(MemDataSize), 64'd2);
    check("dst_b1_rsp", 64'(RspValid), 64'd0);
    tick;
    check("dst_rsp", 64'(RspValid), 64'd1);
    check("dst_loaddata", LoadData, 64'd0);
    check("dst_memen", 64'(MemEnable), 64'd0);
    check("dst_ram10", 64'(ram[10]), 64'hAABB_CCDD);
    check("dst_ram11", 64'(ram[11]), 64'h1122_3344);

    do_req(1'b0, 2'b11, 1'b0, 32'd10, '0, lat, data, err, saw_en);
    check("dld_lat", 64'(lat), 64'd3);
    check("dld_data", data, 64'h1122_3344_AABB_CCDD);

    // back-to-back word loads with ReqValid held
    ReqValid = 1'b1; ReadWrite = 1'b0; DataSize = 2'b10; Address = 32'd10;
    tick;
    Address = 32'd11;
    check("b2b_c1_ready", 64'(ReqReady), 64'd0);
    check("b2b_c1_rsp", 64'(RspValid), 64'd0);
    tick;
    check("b2b_c2_rsp", 64'(RspValid), 64'd1);
    check("b2b_c2_data", LoadData, 64'h0000_0000_AABB_CCDD);
    check("b2b_c2_ready", 64'(ReqReady), 64'd1);
    tick;
    ReqValid = 1'b0;
    check("b2b_c3_rsp", 64'(RspValid), 64'd0);
    check("b2b_c3_en", 64'(MemEnable), 64'd1);
    check("b2b_c3_addr", 64'(MemAddress), 64'd11);
    check("b2b_c3_hold", LoadData, 64'h0000_0000_AABB_CCDD);
    tick;
    check("b2b_c4_rsp", 64'(RspValid), 64'd1);
    check("b2b_c4_data", LoadData, 64'h0000_0000_1122_3344);
    tick;
    check("b2b_c5_rsp", 64'(RspValid), 64'd0);

    // reset during BEAT0 of a doubleword store
    ReqValid = 1'b1; ReadWrite = 1'b1; DataSize = 2'b11; Address = 32'd30;
    StoreData = 64'hDEAD_BEEF_CAFE_F00D;
    tick;
    ReqValid = 1'b0;
    check("mid_b0_en", 64'(MemEnable), 64'd1);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    check("mid_rst_en", 64'(MemEnable), 64'd0);
    check("mid_rst_ready", 64'(ReqReady), 64'd1);
    check("mid_rst_rsp", 64'(RspValid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("mid_after_rsp", 64'(RspValid), 64'd0);
      check("mid_after_en", 64'(MemEnable), 64'd0);
    end
    check("mid_ram31", 64'(ram[31]), 64'd0);

`ifdef DMC_RANGE_CHECK_EN
    do_req(1'b0, 2'b11, 1'b0, 32'd255, '0, lat, data, err, saw_en);
    check("rng_lat", 64'(lat), 64'd1);
    check("rng_err", 64'(err), 64'd1);
    check("rng_data", data, 64'd0);
    check("rng_noen", 64'(saw_en), 64'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'd255, '0, lat, data, err, saw_en);
    check("rng_w255_lat", 64'(lat), 64'd2);
    check("rng_w255_err", 64'(err), 64'd0);
    check("rng_w255_data", data, 64'h0000_0000_55AA_55AA);
    do_req(1'b0, 2'b10, 1'b0, 32'd256, '0, lat, data, err, saw_en);
    check("rng_w256_err", 64'(err), 64'd1);
    check("rng_w256_lat", 64'(lat), 64'd1);
`else
    do_req(1'b0, 2'b11, 1'b0, 32'd255, '0, lat, data, err, saw_en);
    check("norng_lat", 64'(lat), 64'd3);
    check("norng_err", 64'(err), 64'd0);
    check("norng_en", 64'(saw_en), 64'd1);
    check("norng_data", data, 64'h1234_8001_55AA_55AA);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words in the attached data RAM.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ReqValid  input  1  pipeline MEM stage presents a request.
REQ-005 SHALL have port ReqReady  output  1  controller accepts the request this cycle.
REQ-006 SHALL have port ReadWrite  input  1  0 = load, 1 = store.
REQ-007 SHALL have port DataSize  input  2  00 byte, 01 halfword, 10 word, 11 doubleword.
REQ-008 SHALL have port SignedLoad  input  1  sign-extend load result.
REQ-009 SHALL have port Address  input  32  word address into the RAM.
REQ-010 SHALL have port StoreData  input  64  store data; [31:0] first beat, [63:32] second beat.
REQ-011 SHALL have port RspValid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port LoadData  output  64  load result, valid while RspValid=1.
REQ-013 SHALL have port Error  output  1  request rejected, valid while RspValid=1.
REQ-014 SHALL have ports MemEnable (output, 1), MemReadWrite (output, 1), MemAddress (output, 32), MemDataIn (output, 32), MemDataSize (output, 2), and MemDataOut (input, 32), all connected to the data RAM, which has a combinational read.

Function
REQ-015 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-016 SHALL drive ReqReady=1 only in IDLE and RESP; a request is accepted on an edge where ReqValid&ReqReady; on acceptance it latches ReadWrite, DataSize, SignedLoad, Address and StoreData, and the next state is BEAT0.
REQ-017 SHALL in IDLE/RESP without acceptance go to IDLE; ReqValid while busy SHALL be ignored, with no capture.
REQ-018 SHALL in BEAT0 drive MemEnable=1, MemAddress=latched address, MemReadWrite=latched ReadWrite, MemDataSize=latched size, MemDataIn=StoreData[31:0]; a load captures MemDataOut into the low result word at the cycle end.
REQ-019 SHALL go from BEAT0 to BEAT1 if the size is 11, else to RESP.
REQ-020 SHALL in BEAT1 drive MemAddress=address+1 (mod 2^32), MemDataIn=StoreData[63:32] and MemDataSize=10; a load captures MemDataOut into result[63:32]; the next state is RESP.
REQ-021 SHALL drive MemEnable=0 and MemReadWrite=0 in IDLE and RESP.
REQ-022 SHALL in RESP assert RspValid=1 for exactly one cycle; LoadData and Error SHALL hold until the next RESP.
REQ-023 SHALL make RspValid appear 2 cycles after the accepting edge for sizes 00/01/10, and 3 cycles after for size 11.
REQ-024 SHALL form the load result by extending from bit 7 (byte), bit 15 (halfword) or bit 31 (word) to 64 bits: sign extension if SignedLoad=1, else zero extension; a doubleword result is unmodified.
REQ-025 SHALL return LoadData=0 for stores.

Reset
REQ-026 SHALL when Reset=1 at an edge set the state to IDLE, and on the next cycle drive RspValid=0, LoadData=0, Error=0, MemEnable=0, MemReadWrite=0, MemAddress=0, MemDataIn=0, MemDataSize=0 and ReqReady=1.
REQ-027 SHALL when reset occurs mid-operation (BEAT0/BEAT1) abandon the transfer with no RspValid; a second store beat SHALL not be issued.
REQ-028 SHALL give Reset priority over acceptance in the same cycle.

Configuration
REQ-029 SHALL with macro DMC_RANGE_CHECK_EN defined flag a request as out of range at acceptance if Address>=DEPTH, or if the size is 11 and Address+1>=DEPTH; such a request goes IDLE->RESP with no BEAT states, MemEnable stays 0, and RESP has Error=1 and LoadData=0.
REQ-030 SHALL with DMC_RANGE_CHECK_EN undefined tie Error to 0 and pass all addresses through unchecked.

Verification
REQ-031 SHALL test signed byte load: Address=5 holding 0x000000F3, DataSize=00, SignedLoad=1 -> RspValid 2 cycles after accept, LoadData=0xFFFFFFFFFFFFFFF3.
REQ-032 SHALL test doubleword store then load: store StoreData=0x11223344_AABBCCDD at Address=10 -> MemAddress 10 then 11 with data 0xAABBCCDD then 0x11223344; a load of the same address -> LoadData=0x11223344AABBCCDD, RspValid 3 cycles after accept.
REQ-033 SHALL test back-to-back requests: ReqValid held with two word loads -> the second is accepted in the RESP cycle of the first, and RspValid pulses at cycle 2 and cycle 4.
REQ-034 SHALL test reset mid-operation: Reset=1 in the BEAT0 cycle of a doubleword store -> no BEAT1, MemEnable=0 next cycle, no RspValid, and ReqReady=1.
REQ-035 SHALL test range checking with DMC_RANGE_CHECK_EN and DEPTH=256: a doubleword load at Address=255 -> MemEnable never 1, RspValid 1 cycle after accept, Error=1.
REQ-036 SHALL test unsigned halfword load: Address=0 holding 0x1234_8001, DataSize=01, SignedLoad=0 -> LoadData=0x0000000000008001.
